// File: rtl/sdram_sched.sv
// SDRAM init/work sequencer with periodic auto-refresh and write/read arbitration.
// Build option: define SDRAM_SCHED_RR_EN for alternating write/read priority on ties.
module sdram_sched #(
    parameter int T_POWERUP   = 20000,
    parameter int T_RP        = 4,
    parameter int T_RC        = 6,
    parameter int T_RSC       = 6,
    parameter int T_RCD       = 2,
    parameter int CL          = 3,
    parameter int T_WR        = 2,
    parameter int REF_PERIOD  = 780,
    parameter int AR_INIT_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [9:0] wr_burst_len,
    input  logic [9:0] rd_burst_len,
    output logic [4:0] init_state,
    output logic [3:0] work_state,
    output logic [9:0] cnt_clk,
    output logic       sdram_rd_wr,
    output logic       wr_ack,
    output logic       rd_ack,
    output logic       init_done
);

    // Handshake: wr_req/rd_req are level requests sampled only in W_IDLE; the
    // matching ack is a per-word strobe (wr_ack = fetch next word, rd_ack = word
    // valid). A requester holds req until its first ack; req still high when the
    // scheduler returns to W_IDLE is treated as a fresh request.

    localparam logic [4:0] I_NOP  = 5'd0;
    localparam logic [4:0] I_PRE  = 5'd1;
    localparam logic [4:0] I_TRP  = 5'd2;
    localparam logic [4:0] I_AR   = 5'd3;
    localparam logic [4:0] I_TRF  = 5'd4;
    localparam logic [4:0] I_MRS  = 5'd5;
    localparam logic [4:0] I_TRSC = 5'd6;
    localparam logic [4:0] I_DONE = 5'd7;

    localparam logic [3:0] W_IDLE       = 4'd0;
    localparam logic [3:0] W_ACTIVE     = 4'd1;
    localparam logic [3:0] W_TRCD       = 4'd2;
    localparam logic [3:0] W_READ       = 4'd3;
    localparam logic [3:0] W_CL         = 4'd4;
    localparam logic [3:0] W_RD         = 4'd5;
    localparam logic [3:0] W_WRITE      = 4'd6;
    localparam logic [3:0] W_WD         = 4'd7;
    localparam logic [3:0] W_BURST_STOP = 4'd8;
    localparam logic [3:0] W_TWR        = 4'd9;
    localparam logic [3:0] W_PRE        = 4'd10;
    localparam logic [3:0] W_TRP        = 4'd11;
    localparam logic [3:0] W_AR         = 4'd12;
    localparam logic [3:0] W_TRFC       = 4'd13;

    // Terminal count values: a state lasting N cycles exits when its counter reads N-1.
    localparam logic [14:0] NOP_LAST  = 15'(T_POWERUP - 1);
    localparam logic [9:0]  TRP_LAST  = 10'(T_RP - 1);
    localparam logic [9:0]  TRC_LAST  = 10'(T_RC - 1);
    localparam logic [9:0]  TRSC_LAST = 10'(T_RSC - 1);
    localparam logic [9:0]  TRCD_LAST = 10'(T_RCD - 1);
    localparam logic [9:0]  CL_LAST   = 10'(CL - 1);
    localparam logic [9:0]  TWR_LAST  = 10'(T_WR - 1);
    localparam logic [15:0] REF_LAST  = 16'(REF_PERIOD - 1);
    localparam logic [7:0]  AR_INIT   = 8'(AR_INIT_CNT);
    localparam logic [9:0]  CNT_MAX   = 10'd1023;
    localparam logic [9:0]  PAGE_LEN  = 10'd512;

    logic [4:0]  init_next;
    logic [3:0]  work_next;
    logic [14:0] nop_cnt;
    logic [7:0]  ar_cnt;
    logic [15:0] ref_cnt;
    logic        ref_pend;
    logic [9:0]  burst_len;
    logic        pick_wr;
    logic        grant;
    logic        state_chg;

    function automatic logic [9:0] clamp_len(input logic [9:0] len);
        if (len == 10'd0)
            return 10'd1;
        else if (len > PAGE_LEN)
            return PAGE_LEN;
        else
            return len;
    endfunction

`ifdef SDRAM_SCHED_RR_EN
    logic last_wr;

    // On a tie the side that was not granted last wins; last_wr=0 after reset lets write win first.
    always_comb begin
        pick_wr = wr_req && (!rd_req || !last_wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_wr <= 1'b0;
        else if (grant)
            last_wr <= pick_wr;
    end
`else
    always_comb begin
        pick_wr = wr_req;
    end
`endif

    always_comb begin
        grant = (init_state == I_DONE) && (work_state == W_IDLE) && !ref_pend
                && (wr_req || rd_req);
    end

    always_comb begin
        init_next = init_state;
        case (init_state)
            I_NOP:   if (nop_cnt == NOP_LAST) init_next = I_PRE;
            I_PRE:   init_next = I_TRP;
            I_TRP:   if (cnt_clk == TRP_LAST) init_next = I_AR;
            I_AR:    init_next = I_TRF;
            I_TRF:   if (cnt_clk == TRC_LAST) init_next = (ar_cnt == AR_INIT) ? I_MRS : I_AR;
            I_MRS:   init_next = I_TRSC;
            I_TRSC:  if (cnt_clk == TRSC_LAST) init_next = I_DONE;
            I_DONE:  init_next = I_DONE;
            default: init_next = I_NOP;
        endcase
    end

    always_comb begin
        work_next = work_state;
        if (init_state != I_DONE) begin
            work_next = W_IDLE;
        end else begin
            case (work_state)
                W_IDLE: begin
                    if (ref_pend)
                        work_next = W_AR;
                    else if (wr_req || rd_req)
                        work_next = W_ACTIVE;
                end
                W_ACTIVE:     work_next = W_TRCD;
                W_TRCD:       if (cnt_clk == TRCD_LAST) work_next = sdram_rd_wr ? W_READ : W_WRITE;
                W_WRITE:      work_next = (burst_len == 10'd1) ? W_BURST_STOP : W_WD;
                W_WD:         if (cnt_clk == burst_len - 10'd2) work_next = W_BURST_STOP;
                W_BURST_STOP: work_next = W_TWR;
                W_TWR:        if (cnt_clk == TWR_LAST) work_next = W_PRE;
                W_READ:       work_next = W_CL;
                W_CL:         if (cnt_clk == CL_LAST) work_next = W_RD;
                W_RD:         if (cnt_clk == burst_len - 10'd1) work_next = W_PRE;
                W_PRE:        work_next = W_TRP;
                W_TRP:        if (cnt_clk == TRP_LAST) work_next = W_IDLE;
                W_AR:         work_next = W_TRFC;
                W_TRFC:       if (cnt_clk == TRC_LAST) work_next = W_IDLE;
                default:      work_next = W_IDLE;
            endcase
        end
    end

    always_comb begin
        state_chg = (init_next != init_state) || (work_next != work_state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_state <= I_NOP;
            work_state <= W_IDLE;
            cnt_clk    <= 10'd0;
            nop_cnt    <= 15'd0;
            ar_cnt     <= 8'd0;
        end else begin
            init_state <= init_next;
            work_state <= work_next;
            if (state_chg)
                cnt_clk <= 10'd0;
            else if (cnt_clk != CNT_MAX)
                cnt_clk <= cnt_clk + 10'd1;
            if (init_state == I_NOP)
                nop_cnt <= nop_cnt + 15'd1;
            if (init_state == I_AR)
                ar_cnt <= ar_cnt + 8'd1;
        end
    end

    // A new period starting takes precedence over the clear so no expiry is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt  <= 16'd0;
            ref_pend <= 1'b0;
        end else if (init_state == I_DONE) begin
            if (ref_cnt == REF_LAST) begin
                ref_cnt  <= 16'd0;
                ref_pend <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 16'd1;
                if (work_state != W_AR && work_next == W_AR)
                    ref_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_rd_wr <= 1'b1;
            burst_len   <= 10'd1;
        end else if (grant) begin
            sdram_rd_wr <= !pick_wr;
            burst_len   <= clamp_len(pick_wr ? wr_burst_len : rd_burst_len);
        end
    end

    always_comb begin
        wr_ack    = (work_state == W_WRITE) || (work_state == W_WD);
        rd_ack    = (work_state == W_RD);
        init_done = (init_state == I_DONE);
    end

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched: init sequence, transaction table, refresh/arbitration and reset corner cases.
module tb_sdram_sched;

    localparam logic [3:0] W_IDLE       = 4'd0;
    localparam logic [3:0] W_ACTIVE     = 4'd1;
    localparam logic [3:0] W_READ       = 4'd3;
    localparam logic [3:0] W_RD         = 4'd5;
    localparam logic [3:0] W_WRITE      = 4'd6;
    localparam logic [3:0] W_WD         = 4'd7;
    localparam logic [3:0] W_BURST_STOP = 4'd8;
    localparam logic [3:0] W_AR         = 4'd12;

    localparam logic [1:0] GR_AR = 2'd0;
    localparam logic [1:0] GR_WR = 2'd1;
    localparam logic [1:0] GR_RD = 2'd2;

    logic       clk;
    logic       rst;
    logic       wr_req;
    logic       rd_req;
    logic [9:0] wr_burst_len;
    logic [9:0] rd_burst_len;
    logic [4:0] init_state;
    logic [3:0] work_state;
    logic [9:0] cnt_clk;
    logic       sdram_rd_wr;
    logic       wr_ack;
    logic       rd_ack;
    logic       init_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [1:0] log_q[$];
    logic [1:0] exp_q[$];
    logic [3:0] prev_ws = W_IDLE;

    typedef struct {
        logic       is_wr;
        logic [9:0] len;
        int         exp_len;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[9];

    sdram_sched #(
        .T_POWERUP(100), .T_RP(4), .T_RC(6), .T_RSC(6), .T_RCD(2),
        .CL(3), .T_WR(2), .REF_PERIOD(300), .AR_INIT_CNT(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
        .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
        .init_state(init_state), .work_state(work_state), .cnt_clk(cnt_clk),
        .sdram_rd_wr(sdram_rd_wr), .wr_ack(wr_ack), .rd_ack(rd_ack), .init_done(init_done)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // grant logger: records every entry into W_AR or W_ACTIVE
    always @(negedge clk) begin
        if (work_state != prev_ws) begin
            if (work_state == W_AR)
                log_q.push_back(GR_AR);
            else if (work_state == W_ACTIVE)
                log_q.push_back(sdram_rd_wr ? GR_RD : GR_WR);
        end
        prev_ws = work_state;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(work_state == W_IDLE && init_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(work_state == W_IDLE && init_done), 1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (work_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(work_state), 32'(s));
    endtask

    task automatic run_txn(input logic is_wr, input logic [9:0] len, input int exp_len,
                           input int exp_cyc, input string tag);
        int cyc = 0, t_act = -1, t_dat = -1, t_ack = -1, t_bs = -1, t_idle = -1;
        int acks = 0, gaps = 0, wrong = 0;
        logic prev_ack = 1'b0;
        logic ack, other, rdwr = 1'bx;
        wait_idle(400, {tag, "_idle"});
        if (is_wr) begin
            wr_burst_len = len;
            wr_req = 1'b1;
        end else begin
            rd_burst_len = len;
            rd_req = 1'b1;
        end
        while (t_idle < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            ack   = is_wr ? wr_ack : rd_ack;
            other = is_wr ? rd_ack : wr_ack;
            if (t_act < 0 && work_state == W_ACTIVE) begin
                t_act = cyc;
                rdwr  = sdram_rd_wr;
            end
            if (t_act >= 0) begin
                if (t_dat < 0 && work_state == (is_wr ? W_WRITE : W_READ)) t_dat = cyc;
                if (ack) begin
                    acks++;
                    if (t_ack < 0) begin
                        t_ack = cyc;
                        wr_req = 1'b0;
                        rd_req = 1'b0;
                    end else if (!prev_ack) begin
                        gaps++;
                    end
                end
                if (other) wrong++;
                if (t_bs < 0 && work_state == W_BURST_STOP) t_bs = cyc;
                if (work_state == W_IDLE) t_idle = cyc;
            end
            prev_ack = ack;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        check({tag, "_done"}, 32'(t_idle >= 0), 1);
        check({tag, "_acks"}, acks, exp_len);
        check({tag, "_gaps"}, gaps, 0);
        check({tag, "_other_ack"}, wrong, 0);
        check({tag, "_rd_wr"}, 32'(rdwr), 32'(!is_wr));
        check({tag, "_cycles"}, t_idle - t_act, exp_cyc);
        if (is_wr) begin
            check({tag, "_ack_start"}, t_ack - t_dat, 0);
            check({tag, "_burst_stop"}, t_bs - t_ack, exp_len);
        end else begin
            check({tag, "_ack_start"}, t_ack - t_dat, 4);
        end
    endtask

    task automatic check_log(input string tag, input logic drop_ar);
        logic [1:0] got_q[$];
        logic [1:0] e;
        int i = 0;
        foreach (log_q[k])
            if (!(drop_ar && log_q[k] == GR_AR)) got_q.push_back(log_q[k]);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_grant%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'd3, 32'(e));
            i++;
        end
    endtask

    initial begin
        logic [4:0] exp_codes[9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd4, 5'd5, 5'd6};
        int         exp_durs[9]  = '{100, 1, 4, 1, 6, 1, 6, 1, 6};
        logic [4:0] codes[$];
        int         durs[$];
        logic [4:0] cur;
        int         run, done_bad, cnt_bad;
        logic       wr_seen, rd_done;

        vecs[0] = '{1'b1, 10'd8,    8,   19};
        vecs[1] = '{1'b1, 10'd1,    1,   12};
        vecs[2] = '{1'b1, 10'd0,    1,   12};
        vecs[3] = '{1'b1, 10'd513,  512, 523};
        vecs[4] = '{1'b1, 10'd2,    2,   13};
        vecs[5] = '{1'b0, 10'd4,    4,   16};
        vecs[6] = '{1'b0, 10'd0,    1,   13};
        vecs[7] = '{1'b0, 10'd1000, 512, 524};
        vecs[8] = '{1'b0, 10'd7,    7,   19};

        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        wr_burst_len = 10'd0;
        rd_burst_len = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_init_state", 32'(init_state), 0);
        check("rst_work_state", 32'(work_state), 0);
        check("rst_cnt_clk", 32'(cnt_clk), 0);
        check("rst_rd_wr", 32'(sdram_rd_wr), 1);
        check("rst_wr_ack", 32'(wr_ack), 0);
        check("rst_rd_ack", 32'(rd_ack), 0);
        check("rst_init_done", 32'(init_done), 0);

        // init sequence: record each state code and how many cycles it lasted
        rst = 1'b0;
        cur = init_state;
        run = 0;
        done_bad = 0;
        cnt_bad = 0;
        for (int c = 0; c < 400; c++) begin
            if (init_done !== (init_state == 5'd7)) done_bad++;
            if (init_state != cur) begin
                if (cnt_clk != 10'd0) cnt_bad++;
                codes.push_back(cur);
                durs.push_back(run);
                cur = init_state;
                run = 0;
            end
            run++;
            if (init_state == 5'd7) break;
            @(negedge clk);
        end
        check("init_reached_done", 32'(cur), 7);
        check("init_num_states", codes.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("init_code%0d", i), (i < codes.size()) ? 32'(codes[i]) : 32'd31, 32'(exp_codes[i]));
            check($sformatf("init_dur%0d", i), (i < durs.size()) ? durs[i] : -1, exp_durs[i]);
        end
        check("init_done_align", done_bad, 0);
        check("init_cnt_clear", cnt_bad, 0);

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].is_wr, vecs[i].len, vecs[i].exp_len, vecs[i].exp_cyc, $sformatf("vec%0d", i));

        // refresh expires during a page read: burst completes, W_AR follows at once
        run_txn(1'b0, 10'd512, 512, 524, "ref_mid_rd");
        @(negedge clk);
        check("ref_after_burst", 32'(work_state), 32'(W_AR));

        // refresh + write + read all pending in W_IDLE
        wait_idle(400, "tie_idle");
        rd_burst_len = 10'd512;
        rd_req = 1'b1;
        wait_state(W_RD, 200, "tie_reach_rd");
        log_q.delete();
        wr_burst_len = 10'd4;
        rd_burst_len = 10'd4;
        wr_req = 1'b1;
        wr_seen = 1'b0;
        rd_done = 1'b0;
        for (int n = 0; n < 2000 && !rd_done; n++) begin
            @(negedge clk);
            if (wr_ack) begin
                wr_req = 1'b0;
                wr_seen = 1'b1;
            end
            if (wr_seen && rd_ack) begin
                rd_req = 1'b0;
                rd_done = 1'b1;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        check("tie_complete", 32'(rd_done), 1);
        wait_idle(400, "tie_end_idle");
        exp_q.push_back(GR_AR);
        exp_q.push_back(GR_WR);
        exp_q.push_back(GR_RD);
        check_log("tie", 1'b0);

        // repeated ties with both requests held high; last grant above was a read
        wait_idle(400, "alt_idle");
        log_q.delete();
        wr_burst_len = 10'd1;
        rd_burst_len = 10'd1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        repeat (60) @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_idle(400, "alt_end_idle");
`ifdef SDRAM_SCHED_RR_EN
        exp_q.push_back(GR_WR);
        exp_q.push_back(GR_RD);
        exp_q.push_back(GR_WR);
`else
        exp_q.push_back(GR_WR);
        exp_q.push_back(GR_WR);
        exp_q.push_back(GR_WR);
`endif
        check_log("alt", 1'b1);

        // asynchronous reset in the middle of a write burst
        wait_idle(400, "rst_mid_idle");
        wr_burst_len = 10'd64;
        wr_req = 1'b1;
        wait_state(W_WD, 200, "rst_mid_reach_wd");
        wr_req = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_pre_ack", 32'(wr_ack), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_wr_ack", 32'(wr_ack), 0);
        check("rst_mid_work_state", 32'(work_state), 0);
        check("rst_mid_init_state", 32'(init_state), 0);
        check("rst_mid_init_done", 32'(init_done), 0);
        check("rst_mid_cnt_clk", 32'(cnt_clk), 0);
        check("rst_mid_rd_wr", 32'(sdram_rd_wr), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("restart_init_state", 32'(init_state), 0);
        check("restart_init_done", 32'(init_done), 0);
        check("restart_work_state", 32'(work_state), 0);
        check("restart_cnt_clk", 32'(cnt_clk), 30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
